// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer controller: FSM state codes and
// width helpers used by the controller and its FIFOs.
package spi_pkg;

   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_ISSUE = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_HOLD  = 3'd4;

   // Pointer width for a FIFO of the given depth (depth is a power of two).
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Select width for a bank of slave-select lines; never narrower than one bit.
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_fifo.sv
// Small synchronous FIFO used for both the TX and RX byte buffers.
// Head is presented combinationally; writes when full and reads when empty
// are dropped. Storage is cleared on reset so the head never reads X.
module spi_fifo
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  rd,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  full,
   output logic                  empty
);

   localparam int PW = ptr_w(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW:0]           count_q, count_d;
   logic                  push, pop;

   assign full  = (count_q == (PW+1)'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   assign push  = wr & ~full;
   assign pop   = rd & ~empty;
   assign rdata = mem_q[rd_ptr_q];

   // Next-state for storage, pointers and occupancy; pointers wrap naturally.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO registers, cleared asynchronously.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Frame sequencer sitting between a host and an SPI byte engine. Buffers host
// bytes in a TX FIFO, frames them with a slave select plus setup/hold gaps,
// feeds the engine one byte at a time and collects received bytes in an RX FIFO.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no frame; all selects high, waiting for go with nonzero length
//   SETUP | select low, counting cs_gap+1 cycles before the first byte
//   ISSUE | start the engine once TX has data, RX has room, engine ready
//   WAIT  | byte in flight; capture result on engine done tick
//   HOLD  | last byte done, select still low for cs_gap+1 cycles
module spi_xfer_ctrl
   import spi_pkg::*;
#(
   parameter int  DATA_WIDTH = 8,
   parameter int  FIFO_DEPTH = 4,
   parameter int  NUM_SS     = 2,
   localparam int SEL_W      = spi_pkg::sel_w(NUM_SS)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_wr,
   output logic                  tx_full,
   output logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_rd,
   output logic                  rx_empty,
   input  logic [7:0]            xfer_len,
   input  logic [SEL_W-1:0]      ss_sel,
   input  logic [15:0]           cs_gap,
   input  logic                  go,
   output logic                  busy,
   output logic                  xfer_done_tick,
   output logic [DATA_WIDTH-1:0] spi_din,
   output logic                  spi_start,
   input  logic                  spi_ready,
   input  logic                  spi_done_tick,
   input  logic [DATA_WIDTH-1:0] spi_dout,
   output logic [NUM_SS-1:0]     ss_n
);

   state_t            state_q, state_d;
   logic [7:0]        rem_q, rem_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [NUM_SS-1:0] ss_n_q, ss_n_d;

   logic tx_empty, tx_pop;
   logic rx_full, rx_push;
   logic gap_reached;

   spi_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk    (clk),
      .resetn (resetn),
      .wr     (tx_wr),
      .wdata  (tx_data),
      .rd     (tx_pop),
      .rdata  (spi_din),
      .full   (tx_full),
      .empty  (tx_empty)
   );

   spi_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk    (clk),
      .resetn (resetn),
      .wr     (rx_push),
      .wdata  (spi_dout),
      .rd     (rx_rd),
      .rdata  (rx_data),
      .full   (rx_full),
      .empty  (rx_empty)
   );

   // cs_gap is read live; >= keeps a mid-count shrink from running the counter away.
   assign gap_reached = (cnt_q >= cs_gap);
   assign busy        = (state_q != ST_IDLE);
   assign ss_n        = ss_n_q;

   // Frame sequencing: state transitions, byte/gap counters and strobes.
   always_comb begin
      state_d        = state_q;
      rem_d          = rem_q;
      sel_d          = sel_q;
      cnt_d          = cnt_q;
      spi_start      = 1'b0;
      tx_pop         = 1'b0;
      rx_push        = 1'b0;
      xfer_done_tick = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (go && (xfer_len != 8'd0)) begin
               state_d = ST_SETUP;
               rem_d   = xfer_len;
               sel_d   = ss_sel;
               cnt_d   = 16'd0;
            end
         end
         ST_SETUP: begin
            if (gap_reached) begin
               state_d = ST_ISSUE;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_ISSUE: begin
            if (!tx_empty && !rx_full && spi_ready) begin
               spi_start = 1'b1;
               tx_pop    = 1'b1;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (spi_done_tick) begin
               rx_push = 1'b1;
               rem_d   = rem_q - 8'd1;
               if (rem_q == 8'd1) begin
                  state_d = ST_HOLD;
                  cnt_d   = 16'd0;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_HOLD: begin
            if (gap_reached) begin
               state_d        = ST_IDLE;
               cnt_d          = 16'd0;
               xfer_done_tick = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
         end
      endcase
   end

   // Select lines follow the next state so they change on the entry edge.
   always_comb begin
      ss_n_d = '1;
      if (state_d != ST_IDLE) begin
         for (int i = 0; i < NUM_SS; i++) begin
            ss_n_d[i] = (sel_d != SEL_W'(i));
         end
      end
   end

   // Controller registers, forced to idle asynchronously.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         ss_n_q  <= '1;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         ss_n_q  <= ss_n_d;
      end
   end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: a behavioural SPI byte engine (mode 0, divider 4,
// MOSI looped to MISO), a queue-based reference model checked every cycle,
// and directed scenarios with literal expectations.
module tb_spi_xfer_ctrl;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int NSS   = 2;
   localparam int DVSR  = 4;

   logic          clk = 1'b0;
   logic          resetn;
   logic [DW-1:0] tx_data, rx_data, spi_din, spi_dout;
   logic          tx_wr, tx_full, rx_rd, rx_empty;
   logic [7:0]    xfer_len;
   logic [0:0]    ss_sel;
   logic [15:0]   cs_gap;
   logic          go, busy, xfer_done_tick, spi_start, spi_ready, spi_done_tick;
   logic [NSS-1:0] ss_n;

   always #5 clk = ~clk;

   spi_xfer_ctrl #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH),
      .NUM_SS     (NSS)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .tx_data        (tx_data),
      .tx_wr          (tx_wr),
      .tx_full        (tx_full),
      .rx_data        (rx_data),
      .rx_rd          (rx_rd),
      .rx_empty       (rx_empty),
      .xfer_len       (xfer_len),
      .ss_sel         (ss_sel),
      .cs_gap         (cs_gap),
      .go             (go),
      .busy           (busy),
      .xfer_done_tick (xfer_done_tick),
      .spi_din        (spi_din),
      .spi_start      (spi_start),
      .spi_ready      (spi_ready),
      .spi_done_tick  (spi_done_tick),
      .spi_dout       (spi_dout),
      .ss_n           (ss_n)
   );

   // ---------------- byte engine (mode 0, loopback) ----------------
   logic       eng_run, sclk, rx_bit;
   logic [7:0] eng_sh;
   logic [2:0] eng_bit;
   logic [1:0] eng_div;
   logic       mosi, miso;

   assign mosi      = eng_sh[7];
   assign miso      = mosi;
   assign spi_ready = ~eng_run;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         eng_run       <= 1'b0;
         sclk          <= 1'b0;
         rx_bit        <= 1'b0;
         eng_sh        <= '0;
         eng_bit       <= '0;
         eng_div       <= '0;
         spi_done_tick <= 1'b0;
         spi_dout      <= '0;
      end else begin
         spi_done_tick <= 1'b0;
         if (!eng_run) begin
            if (spi_start) begin
               eng_run <= 1'b1;
               eng_sh  <= spi_din;
               eng_div <= '0;
               eng_bit <= '0;
               sclk    <= 1'b0;
            end
         end else if (eng_div == 2'(DVSR - 1)) begin
            eng_div <= '0;
            if (!sclk) begin
               sclk   <= 1'b1;
               rx_bit <= miso;
            end else begin
               sclk   <= 1'b0;
               eng_sh <= {eng_sh[6:0], rx_bit};
               if (eng_bit == 3'd7) begin
                  eng_run       <= 1'b0;
                  spi_done_tick <= 1'b1;
                  spi_dout      <= {eng_sh[6:0], rx_bit};
               end else begin
                  eng_bit <= eng_bit + 3'd1;
               end
            end
         end else begin
            eng_div <= eng_div + 2'd1;
         end
      end
   end

   // ---------------- bookkeeping ----------------
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int starts = 0;
   int dones = 0;
   int go_cyc = 0;
   int first_start_cyc = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Frame phase: 0 idle, 1 select setup, 2 waiting to launch, 3 byte in flight, 4 select hold
   logic [7:0] tx_m[$];
   logic [7:0] rx_m[$];
   int         ph = 0;
   int         left = 0;
   int         bytes_left = 0;
   logic [0:0] m_sel = 1'b0;
   logic [7:0] inflight = '0;

   task automatic model_step();
      logic [1:0] e_ss;
      logic       e_start, e_done, tx_ok, rx_ok;
      if (!resetn) begin
         tx_m.delete();
         rx_m.delete();
         ph = 0;
         left = 0;
         bytes_left = 0;
      end
      e_ss    = (ph == 0) ? 2'b11 : ~(2'b01 << m_sel);
      e_start = (ph == 2) && (tx_m.size() > 0) && (rx_m.size() < DEPTH) && spi_ready;
      e_done  = (ph == 4) && (left == 1);
      chk("ss_n", 32'(ss_n), 32'(e_ss));
      chk("busy", 32'(busy), 32'(ph != 0));
      chk("spi_start", 32'(spi_start), 32'(e_start));
      chk("xfer_done_tick", 32'(xfer_done_tick), 32'(e_done));
      chk("tx_full", 32'(tx_full), 32'(tx_m.size() == DEPTH));
      chk("rx_empty", 32'(rx_empty), 32'(rx_m.size() == 0));
      if (rx_m.size() > 0) chk("rx_data", 32'(rx_data), 32'(rx_m[0]));
      if (spi_start) begin
         starts++;
         if (first_start_cyc < 0) first_start_cyc = cyc;
      end
      if (xfer_done_tick) dones++;
      if (!resetn) return;
      tx_ok = tx_wr && (tx_m.size() < DEPTH);
      rx_ok = rx_rd && (rx_m.size() > 0);
      if (rx_ok) void'(rx_m.pop_front());
      case (ph)
         0: if (go && xfer_len != 8'd0) begin
               ph = 1;
               left = int'(cs_gap) + 1;
               bytes_left = int'(xfer_len);
               m_sel = ss_sel;
            end
         1: if (left == 1) ph = 2; else left--;
         2: if (e_start) begin
               inflight = tx_m.pop_front();
               ph = 3;
            end
         3: if (spi_done_tick) begin
               rx_m.push_back(inflight);
               bytes_left--;
               if (bytes_left == 0) begin
                  ph = 4;
                  left = int'(cs_gap) + 1;
               end else begin
                  ph = 2;
               end
            end
         4: if (left == 1) ph = 0; else left--;
         default: ph = 0;
      endcase
      if (tx_ok) tx_m.push_back(tx_data);
   endtask

   // Compare DUT against the model mid-cycle, when inputs and outputs are stable.
   always @(negedge clk) begin
      #2;
      model_step();
   end

   // ---------------- stimulus helpers (entered and left at a falling edge) ----------------
   task automatic push(input logic [7:0] b);
      tx_data = b;
      tx_wr   = 1'b1;
      @(negedge clk);
      tx_wr   = 1'b0;
   endtask

   task automatic pop_chk(input logic [7:0] exp);
      chk("rx_pop_value", 32'(rx_data), 32'(exp));
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
   endtask

   task automatic start(input logic [7:0] len, input logic [0:0] sel, input logic [15:0] gap);
      xfer_len        = len;
      ss_sel          = sel;
      cs_gap          = gap;
      go              = 1'b1;
      go_cyc          = cyc;
      first_start_cyc = -1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && busy; i++) @(negedge clk);
      chk("wait_idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic wait_starts(input int n, input int budget);
      for (int i = 0; i < budget && starts < n; i++) @(negedge clk);
      chk("wait_start_timeout", 32'(starts >= n), 32'd1);
   endtask

   task automatic wait_tx_space(input int budget);
      for (int i = 0; i < budget && tx_full; i++) @(negedge clk);
      chk("wait_tx_space_timeout", 32'(tx_full), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
      $fatal(1);
   end

   int s0, d0;

   initial begin
      resetn = 1'b0; tx_data = '0; tx_wr = 1'b0; rx_rd = 1'b0;
      xfer_len = '0; ss_sel = '0; cs_gap = '0; go = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ss_n", 32'(ss_n), 32'h3);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_tx_full", 32'(tx_full), 32'h0);
      chk("rst_rx_empty", 32'(rx_empty), 32'h1);
      chk("rst_rx_data", 32'(rx_data), 32'h0);
      chk("rst_spi_start", 32'(spi_start), 32'h0);
      resetn = 1'b1;
      @(negedge clk);

      // Two-byte frame to slave 1 with a three-cycle gap
      push(8'hA5);
      push(8'h3C);
      s0 = starts; d0 = dones;
      start(8'd2, 1'b1, 16'd3);
      wait_starts(s0 + 1, 20);
      chk("s1_start_latency", 32'(first_start_cyc - go_cyc), 32'd5);
      chk("s1_ss_n_mid", 32'(ss_n), 32'h1);
      wait_idle(400);
      chk("s1_done_count", 32'(dones - d0), 32'd1);
      chk("s1_ss_n_after", 32'(ss_n), 32'h3);
      pop_chk(8'hA5);
      pop_chk(8'h3C);
      chk("s1_rx_empty", 32'(rx_empty), 32'h1);

      // Frame started with TX empty; bytes trickle in
      s0 = starts;
      start(8'd3, 1'b0, 16'd2);
      repeat (20) @(negedge clk);
      chk("s2_no_start", 32'(starts - s0), 32'd0);
      chk("s2_busy", 32'(busy), 32'h1);
      chk("s2_ss_n", 32'(ss_n), 32'h2);
      push(8'h11);
      repeat (20) @(negedge clk);
      push(8'h22);
      repeat (20) @(negedge clk);
      push(8'h33);
      wait_idle(500);
      chk("s2_start_count", 32'(starts - s0), 32'd3);
      pop_chk(8'h11);
      pop_chk(8'h22);
      pop_chk(8'h33);

      // Six-byte frame stalls on a full RX FIFO until the host drains it
      push(8'h01); push(8'h02); push(8'h03); push(8'h04);
      s0 = starts;
      start(8'd6, 1'b1, 16'd1);
      wait_tx_space(200);
      push(8'h05);
      wait_tx_space(200);
      push(8'h06);
      repeat (400) @(negedge clk);
      chk("s3_stalled_starts", 32'(starts - s0), 32'd4);
      chk("s3_busy", 32'(busy), 32'h1);
      chk("s3_ss_n_low", 32'(ss_n), 32'h1);
      chk("s3_rx_full_nonempty", 32'(rx_empty), 32'h0);
      pop_chk(8'h01);
      pop_chk(8'h02);
      wait_idle(400);
      chk("s3_total_starts", 32'(starts - s0), 32'd6);
      pop_chk(8'h03); pop_chk(8'h04); pop_chk(8'h05); pop_chk(8'h06);

      // TX overflow drops the fifth byte; zero-length go is ignored
      push(8'h50); push(8'h51); push(8'h52); push(8'h53);
      chk("s4_tx_full_4", 32'(tx_full), 32'h1);
      push(8'h54);
      chk("s4_tx_full_5", 32'(tx_full), 32'h1);
      start(8'd0, 1'b0, 16'd0);
      repeat (5) @(negedge clk);
      chk("s4_len0_busy", 32'(busy), 32'h0);
      chk("s4_len0_ss_n", 32'(ss_n), 32'h3);
      start(8'd4, 1'b0, 16'd0);
      wait_idle(400);
      pop_chk(8'h50); pop_chk(8'h51); pop_chk(8'h52); pop_chk(8'h53);
      chk("s4_rx_empty", 32'(rx_empty), 32'h1);
      chk("s4_tx_drained", 32'(tx_full), 32'h0);

      // Reset during the second byte, then an immediate new frame
      push(8'h71); push(8'h72); push(8'h73);
      s0 = starts;
      start(8'd3, 1'b1, 16'd2);
      wait_starts(s0 + 2, 300);
      repeat (10) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("s5_rst_ss_n", 32'(ss_n), 32'h3);
      chk("s5_rst_busy", 32'(busy), 32'h0);
      chk("s5_rst_rx_empty", 32'(rx_empty), 32'h1);
      chk("s5_rst_tx_full", 32'(tx_full), 32'h0);
      chk("s5_rst_rx_data", 32'(rx_data), 32'h0);
      chk("s5_rst_spi_start", 32'(spi_start), 32'h0);
      @(negedge clk);
      @(negedge clk);
      tx_data  = 8'h81;
      tx_wr    = 1'b1;
      xfer_len = 8'd2;
      ss_sel   = 1'b0;
      cs_gap   = 16'd1;
      go       = 1'b1;
      go_cyc   = cyc;
      first_start_cyc = -1;
      s0       = starts;
      resetn   = 1'b1;
      @(negedge clk);
      go      = 1'b0;
      tx_data = 8'h82;
      @(negedge clk);
      tx_wr   = 1'b0;
      wait_starts(s0 + 1, 20);
      chk("s5_start_latency", 32'(first_start_cyc - go_cyc), 32'd3);
      wait_idle(400);
      pop_chk(8'h81);
      pop_chk(8'h82);
      chk("s5_rx_empty", 32'(rx_empty), 32'h1);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 8, byte-engine word width; FIFO_DEPTH, 4, TX/RX FIFO entries (power of 2, >=2); NUM_SS, 2, slave-select lines.
REQ-002 SHALL have ports (name direction width meaning), clock and reset first:
- clk input 1 single system clock, all logic on rising edge
- resetn input 1 asynchronous active-low reset
- tx_data input DATA_WIDTH host write data; tx_wr input 1 push strobe; tx_full output 1 TX FIFO full
- rx_data output DATA_WIDTH RX FIFO head; rx_rd input 1 pop strobe; rx_empty output 1 RX FIFO empty
- xfer_len input 8 bytes per frame, 1..255; ss_sel input $clog2(NUM_SS) target slave
- cs_gap input 16 slave-select setup/hold, in clk cycles
- go input 1 frame start request; busy output 1 frame in progress; xfer_done_tick output 1 one-cycle frame-complete pulse
- spi_din output DATA_WIDTH byte to engine; spi_start output 1 engine start pulse
- spi_ready input 1 engine idle; spi_done_tick input 1 engine byte done; spi_dout input DATA_WIDTH engine received byte
- ss_n output NUM_SS active-low slave selects, registered

Function
REQ-003 SHALL implement FSM states IDLE, SETUP, ISSUE, WAIT, HOLD.
REQ-004 IDLE: go=1 and xfer_len!=0 -> SETUP; latch xfer_len into remaining counter, latch ss_sel, clear gap counter; go with xfer_len=0 ignored.
REQ-005 SETUP: gap counter increments each cycle; cnt==cs_gap -> ISSUE, clear counter (SETUP lasts cs_gap+1 cycles).
REQ-006 ISSUE: when TX not empty, RX not full and spi_ready=1, spi_start=1 for that cycle, spi_din=TX head, TX popped same cycle, -> WAIT; otherwise stall in ISSUE, no start.
REQ-007 WAIT: on spi_done_tick push spi_dout into RX, decrement remaining; remaining becomes 0 -> HOLD (counter cleared), else -> ISSUE.
REQ-008 HOLD: counts as SETUP; cnt==cs_gap -> IDLE with xfer_done_tick=1 that cycle.
REQ-009 ss_n[latched sel] SHALL be 0 in cycles where state is SETUP/ISSUE/WAIT/HOLD (registered, updated on entry edge); all other bits and IDLE -> all 1.
REQ-010 busy SHALL be 1 in every state except IDLE.
REQ-011 go while busy SHALL be ignored; xfer_len/ss_sel/cs_gap changes mid-frame: xfer_len/ss_sel ignored (latched), cs_gap used live.
REQ-012 spi_start SHALL never assert outside ISSUE and never twice per byte.
REQ-013 FIFOs: tx_wr when full ignored (data dropped); rx_rd when empty ignored; simultaneous push and pop on same FIFO both take effect, count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-014 rx_data SHALL present RX head combinationally; undefined content not required when empty but SHALL not be X after reset (reads 0).
REQ-015 spi_done_tick outside WAIT SHALL be ignored.
REQ-016 Latency: go at cycle 0 -> ss_n low from cycle 1 -> earliest spi_start in cycle cs_gap+2.

Reset
REQ-017 resetn=0 SHALL immediately force state IDLE, ss_n all 1, spi_start 0, busy 0, xfer_done_tick 0, tx_full 0, rx_empty 1, both FIFOs empty, counters 0, regardless of activity (including mid-frame).
REQ-018 Release of resetn SHALL need no further initialisation; first go accepted in first cycle after release.

Structure
REQ-019 State encoding and FIFO pointer-width helper SHALL live in shared package spi_pkg.
REQ-020 TX and RX buffers SHALL be two instances of one sub-module spi_fifo (parameters DATA_WIDTH, FIFO_DEPTH; ports clk, resetn, wr, wdata, rd, rdata, full, empty).

Verification
REQ-021 Bench SHALL connect spi_xfer_ctrl to the byte engine with loopback mosi->miso, dvsr=4, cpol=0, cpha=0.
REQ-022 Scenario: preload 0xA5,0x3C; go, xfer_len=2, ss_sel=1, cs_gap=3 -> ss_n=2'b01 for full frame, RX holds 0xA5,0x3C, one xfer_done_tick, ss_n=2'b11 after.
REQ-023 Scenario: go with xfer_len=3, TX empty; push bytes 20 cycles apart -> controller stalls in ISSUE, no spi_start until data, 3 bytes received in order.
REQ-024 Scenario: FIFO_DEPTH=4, xfer_len=6, no rx_rd -> after 4 bytes stall, ss_n stays low; pop 2 -> remaining bytes complete.
REQ-025 Scenario: 5 tx_wr with depth 4 -> tx_full=1 after fourth, fifth dropped; go, xfer_len=0 -> busy stays 0.
REQ-026 Scenario: assert resetn=0 during WAIT of byte 2 -> ss_n all 1 same cycle, FIFOs empty, busy 0; new frame after release completes normally.
